// File: rtl/td4_sequencer.sv
// td4_sequencer: fetch/exec/write control sequencer for the TTM4 4-bit datapath.
// Decodes the ROM word, drives the register-stack strobes and bus enables,
// steers the PC counter and holds the carry flag. All outputs are registered.
module td4_sequencer #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter bit          RESET_RUN   = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
  input  logic       STEP,
  input  logic [7:0] INSTR,
  input  logic       CARRY,
  output logic       nA_ST,
  output logic       nB_ST,
  output logic       nOUT_ST,
  output logic       nPC_ST,
  output logic       PC_INC,
  output logic       nA_OUT,
  output logic       nB_OUT,
  output logic       nIN_OUT,
  output logic [3:0] IMM,
  output logic       C_FLAG,
  output logic       BUSY,
  output logic       INSTR_DONE
);

  typedef enum logic [1:0] {ST_FETCH = 2'd0, ST_EXEC = 2'd1, ST_WRITE = 2'd2} state_t;
  typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_A = 2'd1, SRC_B = 2'd2, SRC_IN = 2'd3} src_t;
  typedef enum logic [2:0] {DST_NONE = 3'd0, DST_A = 3'd1, DST_B = 3'd2, DST_OUT = 3'd3,
                            DST_PC = 3'd4, DST_JNC = 3'd5} dst_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  // Bus source selected by an opcode (immediate-only ops leave the bus undriven).
  function automatic src_t decode_src(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0100:          decode_src = SRC_A;
      4'b0101, 4'b0001, 4'b1001: decode_src = SRC_B;
      4'b0010, 4'b0110:          decode_src = SRC_IN;
      default:                   decode_src = SRC_NONE;
    endcase
  endfunction

  // Destination written in the WRITE cycle.
  function automatic dst_t decode_dst(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0011, 4'b0001, 4'b0010: decode_dst = DST_A;
      4'b0101, 4'b0111, 4'b0100, 4'b0110: decode_dst = DST_B;
      4'b1001, 4'b1011:                   decode_dst = DST_OUT;
      4'b1111:                            decode_dst = DST_PC;
      4'b1110:                            decode_dst = DST_JNC;
      default:                            decode_dst = DST_NONE;
    endcase
  endfunction

  // Only the two ADD opcodes capture the adder carry.
  function automatic logic is_add(input logic [3:0] op);
    is_add = (op == 4'b0000) || (op == 4'b0101);
  endfunction

  state_t     state_r, state_nxt_s;
  logic [3:0] wait_cnt_r, wait_cnt_nxt_s;
  logic [7:0] ir_r, ir_nxt_s;
  logic [3:0] imm_r, imm_nxt_s;
  logic       step_d_r, step_seen_r, step_edge_s, run_ok_s, advance_s;
  logic       c_flag_r, c_flag_nxt_s;
  src_t       src_s;
  dst_t       dst_s;
  logic       busy_nxt_s, write_nxt_s, jump_s;
  logic       a_st_n_r, b_st_n_r, out_st_n_r, pc_st_n_r, pc_inc_r;
  logic       a_oe_n_r, b_oe_n_r, in_oe_n_r, busy_r, done_r;

  // Next-state, instruction capture and carry-flag update.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    step_edge_s    = STEP & ~step_d_r;
    run_ok_s       = RUN & (RESET_RUN | step_seen_r);
    advance_s      = 1'b0;
    case (state_r)
      ST_FETCH: begin
        // A step edge only counts while halted; in free-run it is dropped.
        advance_s = run_ok_s | (step_edge_s & ~RUN);
        if (advance_s) begin
          state_nxt_s    = ST_EXEC;
          wait_cnt_nxt_s = 4'd0;
        end else begin
          state_nxt_s    = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (wait_cnt_r == WAIT_LAST) begin
          state_nxt_s = ST_WRITE;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + 4'd1;
        end
      end
      ST_WRITE: state_nxt_s = ST_FETCH;
      default:  state_nxt_s = ST_FETCH;
    endcase
    ir_nxt_s     = advance_s ? INSTR : ir_r;
    imm_nxt_s    = advance_s ? INSTR[3:0] : imm_r;
    c_flag_nxt_s = (state_r == ST_WRITE) ? (is_add(ir_r[7:4]) & CARRY) : c_flag_r;
  end

  // Output decode one cycle ahead so the registered outputs line up with the state.
  always_comb begin
    src_s       = decode_src(ir_nxt_s[7:4]);
    dst_s       = decode_dst(ir_nxt_s[7:4]);
    busy_nxt_s  = (state_nxt_s != ST_FETCH);
    write_nxt_s = (state_nxt_s == ST_WRITE);
    // JNC sees the flag as it stood before this WRITE.
    jump_s      = (dst_s == DST_PC) || ((dst_s == DST_JNC) && !c_flag_r);
  end

  // Sequencer state, instruction register, step edge tracking and carry flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= ST_FETCH;
      wait_cnt_r  <= 4'd0;
      ir_r        <= 8'h00;
      imm_r       <= 4'd0;
      step_d_r    <= 1'b0;
      step_seen_r <= 1'b0;
      c_flag_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      wait_cnt_r  <= wait_cnt_nxt_s;
      ir_r        <= ir_nxt_s;
      imm_r       <= imm_nxt_s;
      step_d_r    <= STEP;
      step_seen_r <= step_seen_r | step_edge_s;
      c_flag_r    <= c_flag_nxt_s;
    end
  end

  // Registered strobes and enables, glitch-free toward the register stack.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_st_n_r   <= 1'b1;
      b_st_n_r   <= 1'b1;
      out_st_n_r <= 1'b1;
      pc_st_n_r  <= 1'b1;
      pc_inc_r   <= 1'b0;
      a_oe_n_r   <= 1'b1;
      b_oe_n_r   <= 1'b1;
      in_oe_n_r  <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      a_st_n_r   <= ~(write_nxt_s && (dst_s == DST_A));
      b_st_n_r   <= ~(write_nxt_s && (dst_s == DST_B));
      out_st_n_r <= ~(write_nxt_s && (dst_s == DST_OUT));
      pc_st_n_r  <= ~(write_nxt_s && jump_s);
      pc_inc_r   <= write_nxt_s && !jump_s;
      a_oe_n_r   <= ~(busy_nxt_s && (src_s == SRC_A));
      b_oe_n_r   <= ~(busy_nxt_s && (src_s == SRC_B));
      in_oe_n_r  <= ~(busy_nxt_s && (src_s == SRC_IN));
      busy_r     <= busy_nxt_s;
      done_r     <= (state_r == ST_WRITE);
    end
  end

  assign nA_ST      = a_st_n_r;
  assign nB_ST      = b_st_n_r;
  assign nOUT_ST    = out_st_n_r;
  assign nPC_ST     = pc_st_n_r;
  assign PC_INC     = pc_inc_r;
  assign nA_OUT     = a_oe_n_r;
  assign nB_OUT     = b_oe_n_r;
  assign nIN_OUT    = in_oe_n_r;
  assign IMM        = imm_r;
  assign C_FLAG     = c_flag_r;
  assign BUSY       = busy_r;
  assign INSTR_DONE = done_r;

endmodule

// File: tb/tb_td4_sequencer.sv
// Bench for td4_sequencer: table-driven instruction model, randomized programs,
// single-step, run-drop and asynchronous reset scenarios.
module tb_td4_sequencer;

  localparam int WAIT_CYCLES = 1;

  logic       CLK = 1'b0;
  logic       RST, RUN, STEP, CARRY;
  logic [7:0] INSTR;
  logic       nA_ST, nB_ST, nOUT_ST, nPC_ST, PC_INC, nA_OUT, nB_OUT, nIN_OUT;
  logic [3:0] IMM;
  logic       C_FLAG, BUSY, INSTR_DONE;

  int checks = 0;
  int failures = 0;

  // Instruction table from the datasheet: source 0 none/1 A/2 B/3 IN;
  // destination 0 none/1 A/2 B/3 OUT/4 JMP/5 JNC.
  int src_tab [16];
  int dst_tab [16];
  bit add_tab [16];
  logic m_c_flag;

  td4_sequencer #(.WAIT_CYCLES(WAIT_CYCLES), .RESET_RUN(1'b1)) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP), .INSTR(INSTR), .CARRY(CARRY),
    .nA_ST(nA_ST), .nB_ST(nB_ST), .nOUT_ST(nOUT_ST), .nPC_ST(nPC_ST), .PC_INC(PC_INC),
    .nA_OUT(nA_OUT), .nB_OUT(nB_OUT), .nIN_OUT(nIN_OUT), .IMM(IMM), .C_FLAG(C_FLAG),
    .BUSY(BUSY), .INSTR_DONE(INSTR_DONE)
  );

  always #5 CLK = ~CLK;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // At most one bus driver may be enabled at any time.
  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      checks++;
      if ((32'(!nA_OUT) + 32'(!nB_OUT) + 32'(!nIN_OUT)) > 32'd1) begin
        failures++;
        $display("FAIL bus_onehot: got nA_OUT=%b nB_OUT=%b nIN_OUT=%b, need at most one low",
                 nA_OUT, nB_OUT, nIN_OUT);
      end
    end
  end

  function automatic logic [9:0] out_vec();
    return {nA_ST, nB_ST, nOUT_ST, nPC_ST, PC_INC, nA_OUT, nB_OUT, nIN_OUT, BUSY, INSTR_DONE};
  endfunction

  // Expected outputs per phase: 0 first fetch after write, 1 exec, 2 write, 3 idle fetch.
  function automatic logic [9:0] model_vec(input int ph, input int s, input int d, input logic jmp);
    logic busy, done;
    busy = (ph == 1) || (ph == 2);
    done = (ph == 0);
    return {!(ph == 2 && d == 1), !(ph == 2 && d == 2), !(ph == 2 && d == 3),
            !(ph == 2 && jmp), (ph == 2 && !jmp),
            !(busy && s == 1), !(busy && s == 2), !(busy && s == 3), busy, done};
  endfunction

  // Execute one instruction back-to-back from a FETCH cycle and check every cycle.
  task automatic run_instr(input logic [7:0] ins, input logic cy, input string tag);
    int s, d;
    logic jmp;
    logic [9:0] exp_v, got_v;
    s = src_tab[ins[7:4]];
    d = dst_tab[ins[7:4]];
    jmp = (d == 4) || (d == 5 && !m_c_flag);
    INSTR = ins;
    CARRY = cy;
    for (int e = 0; e <= WAIT_CYCLES; e++) begin
      @(negedge CLK);
      exp_v = model_vec(1, s, d, jmp);
      got_v = out_vec();
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL %s exec%0d ins=%h: got %b need %b", tag, e, ins, got_v, exp_v);
      end
      checks++;
      if (IMM !== ins[3:0]) begin
        failures++;
        $display("FAIL %s imm ins=%h: got %h need %h", tag, ins, IMM, ins[3:0]);
      end
    end
    @(negedge CLK);
    exp_v = model_vec(2, s, d, jmp);
    got_v = out_vec();
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s write ins=%h cflag=%b: got %b need %b", tag, ins, m_c_flag, got_v, exp_v);
    end
    m_c_flag = add_tab[ins[7:4]] ? cy : 1'b0;
    @(negedge CLK);
    exp_v = model_vec(0, s, d, jmp);
    got_v = out_vec();
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s done ins=%h: got %b need %b", tag, ins, got_v, exp_v);
    end
    checks++;
    if (C_FLAG !== m_c_flag) begin
      failures++;
      $display("FAIL %s cflag ins=%h: got %b need %b", tag, ins, C_FLAG, m_c_flag);
    end
  endtask

  task automatic test_reset();
    logic [9:0] exp_v;
    RST = 1'b0; RUN = 1'b1; STEP = 1'b0; INSTR = 8'h35; CARRY = 1'b0;
    m_c_flag = 1'b0;
    repeat (2) @(negedge CLK);
    exp_v = model_vec(3, 0, 0, 1'b0);
    checks++;
    if (out_vec() !== exp_v || IMM !== 4'd0 || C_FLAG !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got vec=%b imm=%h c=%b need vec=%b imm=0 c=0",
               out_vec(), IMM, C_FLAG, exp_v);
    end
    RST = 1'b1;
  endtask

  task automatic test_timing();
    run_instr(8'h35, 1'b0, "mov_a_timing");
  endtask

  task automatic test_add_carry_jnc();
    run_instr(8'h0F, 1'b1, "add_carry");
    run_instr(8'hE7, 1'b0, "jnc_not_taken");
    run_instr(8'hE7, 1'b0, "jnc_taken");
    run_instr(8'hF3, 1'b1, "jmp");
  endtask

  task automatic test_move_out();
    run_instr(8'h40, 1'b0, "mov_b_a");
    run_instr(8'h90, 1'b0, "out_b");
    run_instr(8'h2C, 1'b0, "in_a");
    run_instr(8'h5A, 1'b1, "add_b");
  endtask

  task automatic test_nop();
    run_instr(8'h0F, 1'b1, "nop_setup");
    run_instr(8'h80, 1'b1, "nop");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_instr(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_single_step();
    int  done_cnt;
    logic busy_at_step2;
    done_cnt = 0;
    busy_at_step2 = 1'b0;
    RUN = 1'b0;
    INSTR = 8'h80;
    for (int c = 0; c < 16; c++) begin
      STEP = (c == 0 || c == 2 || c == 8) ? 1'b1 : 1'b0;
      if (c == 2) busy_at_step2 = BUSY;
      @(negedge CLK);
      if (INSTR_DONE === 1'b1) done_cnt++;
    end
    STEP = 1'b0;
    m_c_flag = 1'b0;
    checks++;
    if (busy_at_step2 !== 1'b1) begin
      failures++;
      $display("FAIL step_during_busy: got BUSY=%b need 1", busy_at_step2);
    end
    checks++;
    if (done_cnt != 2) begin
      failures++;
      $display("FAIL single_step_count: got %0d done pulses need 2", done_cnt);
    end
    checks++;
    if (BUSY !== 1'b0 || C_FLAG !== 1'b0) begin
      failures++;
      $display("FAIL single_step_idle: got BUSY=%b C_FLAG=%b need 0 0", BUSY, C_FLAG);
    end
  endtask

  task automatic test_run_drop();
    int a_st_cnt, done_cnt;
    a_st_cnt = 0;
    done_cnt = 0;
    RUN = 1'b1;
    INSTR = 8'h35;
    @(negedge CLK);
    RUN = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (nA_ST === 1'b0) a_st_cnt++;
      if (INSTR_DONE === 1'b1) done_cnt++;
    end
    m_c_flag = 1'b0;
    checks++;
    if (a_st_cnt != 1 || done_cnt != 1) begin
      failures++;
      $display("FAIL run_drop: got nA_ST lows=%0d done=%0d need 1 1", a_st_cnt, done_cnt);
    end
    checks++;
    if (BUSY !== 1'b0) begin
      failures++;
      $display("FAIL run_drop_idle: got BUSY=%b need 0", BUSY);
    end
  endtask

  task automatic test_reset_mid_exec();
    logic [9:0] idle_v;
    idle_v = model_vec(3, 0, 0, 1'b0);
    RUN = 1'b1;
    run_instr(8'h0F, 1'b1, "rst_setup");
    INSTR = 8'h03;
    CARRY = 1'b1;
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b1 || nA_OUT !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_exec_pre: got BUSY=%b nA_OUT=%b need 1 0", BUSY, nA_OUT);
    end
    #2;
    RST = 1'b0;
    RUN = 1'b0;
    #1;
    m_c_flag = 1'b0;
    checks++;
    if (out_vec() !== idle_v || C_FLAG !== 1'b0 || IMM !== 4'd0) begin
      failures++;
      $display("FAIL rst_async: got vec=%b c=%b imm=%h need vec=%b c=0 imm=0",
               out_vec(), C_FLAG, IMM, idle_v);
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checks++;
      if (out_vec() !== idle_v) begin
        failures++;
        $display("FAIL rst_release_idle%0d: got %b need %b", c, out_vec(), idle_v);
      end
    end
    RUN = 1'b1;
    run_instr(8'h35, 1'b0, "after_reset");
    RUN = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      src_tab[i] = 0;
      dst_tab[i] = 0;
      add_tab[i] = 1'b0;
    end
    src_tab[0]  = 1; dst_tab[0]  = 1; add_tab[0] = 1'b1;
    src_tab[5]  = 2; dst_tab[5]  = 2; add_tab[5] = 1'b1;
    dst_tab[3]  = 1;
    dst_tab[7]  = 2;
    src_tab[1]  = 2; dst_tab[1]  = 1;
    src_tab[4]  = 1; dst_tab[4]  = 2;
    src_tab[2]  = 3; dst_tab[2]  = 1;
    src_tab[6]  = 3; dst_tab[6]  = 2;
    src_tab[9]  = 2; dst_tab[9]  = 3;
    dst_tab[11] = 3;
    dst_tab[15] = 4;
    dst_tab[14] = 5;

    test_reset();
    test_timing();
    test_add_carry_jnc();
    test_move_out();
    test_nop();
    test_random();
    test_single_step();
    test_run_drop();
    test_reset_mid_exec();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
